thread_fetch_sched: RTL

- Fetch scheduler for the 4-thread pipeline.
- Each cycle it selects one hardware thread in round-robin order and presents that thread's instruction-memory address to the shared instruction memory.
- Holds one 8-bit PC per thread, program-length limits, and per-thread run/done state.
- Applies branch/jump redirects resolved in the MEM stage. Replaces the ad-hoc per-thread PC and sign-rotation logic in the IF stage.

---
 rtl/thread_fetch_sched_pkg.sv | 22 ++
 rtl/rr_arbiter_4.sv | 29 ++
 rtl/thread_fetch_sched.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/thread_fetch_sched_pkg.sv
// Shared definitions for the 4-thread fetch scheduler.
//   NTHR, PCW        : thread count and per-thread PC width
//   thr_state_e      : per-thread run state (IDLE / RUN / DONE)
//   prog_len_at()    : extracts one thread's program length from the packed bus
package thread_fetch_sched_pkg;

    localparam int NTHR = 4;
    localparam int PCW  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } thr_state_e;

    // Thread tid's length lives in lens[PCW*tid +: PCW].
    function automatic logic [PCW-1:0] prog_len_at(input logic [NTHR*PCW-1:0] lens,
                                                   input logic [1:0]           tid);
        return lens[tid*PCW +: PCW];
    endfunction

endpackage

// File: rtl/rr_arbiter_4.sv
// Combinational 4-way round-robin arbiter.
//   req   [3:0] : request per thread
//   last  [1:0] : most recent grant; search starts at last+1
//   grant [1:0] : selected thread (equals last when nothing requests)
//   valid       : at least one request was granted
module rr_arbiter_4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] grant,
    output logic       valid
);

    logic [1:0] idx;

    // Search order last+1, last+2, last+3, last (mod 4); first hit wins.
    always_comb begin
        grant = last;
        valid = 1'b0;
        idx   = last;
        for (int k = 1; k <= 4; k++) begin
            idx = last + k[1:0];
            if (!valid && req[idx]) begin
                valid = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/thread_fetch_sched.sv
// Round-robin fetch scheduler for the 4-thread pipeline. Holds one PC and a
// run state per thread, picks one running thread per cycle and presents
// {tid, pc} to the shared instruction memory. Applies MEM-stage redirects.
//   clk, rst     : clock, asynchronous active-low reset
//   thr_en       : per-thread enable (0 forces the thread IDLE and clears PC)
//   prog_len     : packed per-thread program lengths, thread i in [8i+7:8i]
//   stall        : freezes every register in the block
//   redir_*      : taken branch/jump target for one thread
//   fetch_valid  : fetch_tid/fetch_addr carry an issue this cycle
//   fetch_tid    : issued thread
//   fetch_addr   : {tid, pc} instruction-memory address
//   thr_done     : per-thread DONE flag
//   dbg_state    : per-thread state register, thread i in [2i+1:2i]
//
// Handshake: fetch_valid is a one-cycle valid with no ready; the consumer must
// take the address in the cycle it is valid. Back-pressure is only via stall,
// which holds fetch_valid/fetch_tid/fetch_addr stable for its duration.
module thread_fetch_sched
    import thread_fetch_sched_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NTHR-1:0]      thr_en,
    input  logic [NTHR*PCW-1:0]  prog_len,
    input  logic                 stall,
    input  logic                 redir_valid,
    input  logic [1:0]           redir_tid,
    input  logic [PCW-1:0]       redir_pc,
    output logic                 fetch_valid,
    output logic [1:0]           fetch_tid,
    output logic [PCW+1:0]       fetch_addr,
    output logic [NTHR-1:0]      thr_done,
    output logic [2*NTHR-1:0]    dbg_state
);

    thr_state_e     st_q [NTHR];
    thr_state_e     st_d [NTHR];
    logic [PCW-1:0] pc_q [NTHR];
    logic [PCW-1:0] pc_d [NTHR];
    logic [1:0]     rr_q;
    logic [NTHR-1:0] req;
    logic [NTHR-1:0] done_d;
    logic [1:0]     gnt;
    logic           gnt_v;
    logic [PCW-1:0] len_i;

    // A thread being redirected this cycle is masked so the redirect wins.
    always_comb begin
        for (int i = 0; i < NTHR; i++) begin
            req[i] = (st_q[i] == ST_RUN) && !(redir_valid && (redir_tid == i[1:0]));
        end
    end

    rr_arbiter_4 u_arb (
        .req   (req),
        .last  (rr_q),
        .grant (gnt),
        .valid (gnt_v)
    );

    // Per-thread next state and next PC.
    always_comb begin
        len_i = '0;
        for (int i = 0; i < NTHR; i++) begin
            st_d[i] = st_q[i];
            pc_d[i] = pc_q[i];
            len_i   = prog_len_at(prog_len, i[1:0]);
            if (!stall) begin
                if (!thr_en[i]) begin
                    st_d[i] = ST_IDLE;
                    pc_d[i] = '0;
                end else if (redir_valid && (redir_tid == i[1:0]) && (st_q[i] != ST_IDLE)) begin
                    pc_d[i] = redir_pc;
                    st_d[i] = (redir_pc >= len_i) ? ST_DONE : ST_RUN;
                end else begin
                    case (st_q[i])
                        ST_IDLE: begin
                            if (len_i != '0) st_d[i] = ST_RUN;
                        end
                        ST_RUN: begin
                            if (gnt_v && (gnt == i[1:0])) begin
                                pc_d[i] = pc_q[i] + 1'b1;
                                // Compare one bit wider so PC 255 does not wrap past the limit.
                                if (({1'b0, pc_q[i]} + 9'd1) >= {1'b0, len_i}) st_d[i] = ST_DONE;
                            end
                        end
                        ST_DONE: begin
                            st_d[i] = ST_DONE;
                        end
                        default: begin
                            st_d[i] = ST_IDLE;
                        end
                    endcase
                end
            end
            done_d[i] = (st_d[i] == ST_DONE);
        end
    end

    always_comb begin
        dbg_state = '0;
        for (int i = 0; i < NTHR; i++) begin
            dbg_state[2*i +: 2] = st_q[i];
        end
    end

    // State and PC registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NTHR; i++) begin
                st_q[i] <= ST_IDLE;
                pc_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NTHR; i++) begin
                st_q[i] <= st_d[i];
                pc_q[i] <= pc_d[i];
            end
        end
    end

    // Output registers and round-robin pointer. rr_q resets to 3 so thread 0
    // is searched first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_valid <= 1'b0;
            fetch_tid   <= '0;
            fetch_addr  <= '0;
            thr_done    <= '0;
            rr_q        <= 2'd3;
        end else if (!stall) begin
            fetch_valid <= gnt_v;
            thr_done    <= done_d;
            if (gnt_v) begin
                fetch_tid  <= gnt;
                fetch_addr <= {gnt, pc_q[gnt]};
                rr_q       <= gnt;
            end
        end
    end

endmodule
